// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the program-memory boot controller.
package imem_pkg;
  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;
endpackage

// File: rtl/imem_ram.sv
// DEPTH x DW program RAM: one synchronous write port, one registered read port.
module imem_ram #(
  parameter int AW    = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Read register only updates on a read, so rdata holds between fetches.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer for the program memory: clears every word, loads a program
// stream from the loader, then serves single-cycle-latency CPU fetches.
module imem_boot_ctrl
  import imem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          reload,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_valid,
  output logic [DW-1:0] fetch_data,
  output logic          prog_ready,
  output logic          busy,
  output logic [AW:0]   load_count,
  output logic          err_overflow
);
  state_t        state_reg;
  logic [AW-1:0] clr_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW:0]   load_count_reg;
  logic          err_overflow_reg;
  logic          fetch_valid_reg;
  logic          rd_seen_reg;

  logic          ld_accept;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  always_comb begin
    busy       = (state_reg == CLEAR) || (state_reg == LOAD);
    prog_ready = (state_reg == RUN);
    ld_ready   = (state_reg == LOAD);
    ld_accept  = ld_ready && ld_valid;
    // Write port belongs to the clear engine in CLEAR, to the loader in LOAD.
    mem_we     = !rst && ((state_reg == CLEAR) || ld_accept);
    mem_waddr  = (state_reg == CLEAR) ? clr_ptr_reg : wr_ptr_reg;
    mem_wdata  = (state_reg == CLEAR) ? '0 : ld_data;
    mem_re     = !rst && (state_reg == RUN) && fetch_req;
  end

  imem_ram #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (fetch_addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= CLEAR;
      clr_ptr_reg      <= '0;
      wr_ptr_reg       <= '0;
      load_count_reg   <= '0;
      err_overflow_reg <= 1'b0;
      fetch_valid_reg  <= 1'b0;
      rd_seen_reg      <= 1'b0;
    end else begin
      fetch_valid_reg <= mem_re;
      if (mem_re) rd_seen_reg <= 1'b1;
      case (state_reg)
        CLEAR: begin
          clr_ptr_reg <= clr_ptr_reg + 1'b1;
          if (clr_ptr_reg == AW'(DEPTH - 1)) begin
            state_reg  <= LOAD;
            wr_ptr_reg <= '0;
          end
        end
        LOAD: begin
          if (ld_accept) begin
            wr_ptr_reg     <= wr_ptr_reg + 1'b1;
            load_count_reg <= load_count_reg + 1'b1;
            if (ld_last || (wr_ptr_reg == AW'(DEPTH - 1))) state_reg <= RUN;
            if (!ld_last && (wr_ptr_reg == AW'(DEPTH - 1))) err_overflow_reg <= 1'b1;
          end
        end
        RUN: begin
          if (reload) begin
            state_reg        <= CLEAR;
            clr_ptr_reg      <= '0;
            wr_ptr_reg       <= '0;
            load_count_reg   <= '0;
            err_overflow_reg <= 1'b0;
          end
        end
        default: state_reg <= CLEAR;
      endcase
    end
  end

  // The RAM read register has no reset; mask it until the first real fetch.
  assign fetch_data   = rd_seen_reg ? mem_rdata : '0;
  assign fetch_valid  = fetch_valid_reg;
  assign load_count   = load_count_reg;
  assign err_overflow = err_overflow_reg;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: clear/load/run sequencing, fetches,
// overflow, reload and mid-load reset.
module tb_imem_boot_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        reload = 1'b0;
  logic        fetch_req = 1'b0;
  logic [7:0]  fetch_addr = '0;
  logic        fetch_valid;
  logic [15:0] fetch_data;
  logic        prog_ready;
  logic        busy;
  logic [8:0]  load_count;
  logic        err_overflow;

  int errors = 0;
  int checks = 0;

  imem_boot_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .ld_last      (ld_last),
    .ld_ready     (ld_ready),
    .reload       (reload),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_valid  (fetch_valid),
    .fetch_data   (fetch_data),
    .prog_ready   (prog_ready),
    .busy         (busy),
    .load_count   (load_count),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(input string tag);
    int n;
    n = 0;
    while (!ld_ready && n < 400) begin
      step();
      n++;
    end
    chk(tag, n, 256);
  endtask

  task automatic send_word(input logic [15:0] d, input logic last, input bit gap);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (gap) step();
  endtask

  task automatic do_fetch(input string tag, input logic [7:0] a, input logic [15:0] exp);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    fetch_req  = 1'b0;
    chk({tag, "_valid"}, fetch_valid, 1);
    chk({tag, "_data"}, fetch_data, exp);
    $display("fetch %s addr=%0d data=0x%04h", tag, a, fetch_data);
  endtask

  initial begin
    int fv_seen;
    int n;

    // Reset state
    step();
    step();
    chk("rst_busy", busy, 1);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_prog_ready", prog_ready, 0);
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_load_count", load_count, 0);
    chk("rst_err", err_overflow, 0);
    rst = 1'b0;

    // CLEAR lasts 256 cycles; fetches are ignored throughout
    fv_seen = 0;
    n = 0;
    fetch_req = 1'b1;
    while (!ld_ready && n < 400) begin
      fetch_addr = n[7:0];
      step();
      n++;
      if (fetch_valid) fv_seen++;
    end
    chk("clear_cycles", n, 256);
    step();
    if (fetch_valid) fv_seen++;
    chk("fetch_ignored_clear_load", fv_seen, 0);
    chk("load_busy", busy, 1);
    fetch_req = 1'b0;
    $display("clear done after %0d cycles", n);

    // Three-word program with valid gaps
    send_word(16'h1234, 1'b0, 1'b1);
    send_word(16'hABCD, 1'b0, 1'b1);
    send_word(16'h0F0F, 1'b1, 1'b1);
    chk("p3_load_count", load_count, 3);
    chk("p3_prog_ready", prog_ready, 1);
    chk("p3_busy", busy, 0);
    chk("p3_err", err_overflow, 0);
    $display("load3 count=%0d prog_ready=%0b", load_count, prog_ready);

    // Pipelined fetches 0..3, one per cycle
    for (int a = 0; a < 4; a++) begin
      logic [15:0] exp;
      case (a)
        0: exp = 16'h1234;
        1: exp = 16'hABCD;
        2: exp = 16'h0F0F;
        default: exp = 16'h0000;
      endcase
      fetch_req  = 1'b1;
      fetch_addr = 8'(a);
      step();
      chk("pipe_valid", fetch_valid, 1);
      chk("pipe_data", fetch_data, 32'(exp));
      $display("pipe fetch addr=%0d data=0x%04h", a, fetch_data);
    end
    fetch_req = 1'b0;
    step();
    chk("pipe_idle_valid", fetch_valid, 0);

    // Reload, then 256 words without ld_last
    reload = 1'b1;
    step();
    reload = 1'b0;
    chk("reload1_busy", busy, 1);
    wait_load("reload1_clear_cycles");
    for (int i = 0; i < 256; i++) send_word(16'(i), 1'b0, 1'b0);
    chk("ovf_prog_ready", prog_ready, 1);
    chk("ovf_load_count", load_count, 256);
    chk("ovf_err", err_overflow, 1);
    $display("load256 count=%0d err=%0b", load_count, err_overflow);
    do_fetch("ovf_255", 8'd255, 16'h00FF);
    do_fetch("ovf_7", 8'd7, 16'h0007);

    // Reload with a same-cycle fetch: served with pre-clear data
    reload     = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 8'd1;
    step();
    reload    = 1'b0;
    fetch_req = 1'b0;
    chk("rf_valid", fetch_valid, 1);
    chk("rf_data", fetch_data, 32'h0001);
    chk("rf_busy", busy, 1);
    chk("rf_err", err_overflow, 0);
    chk("rf_load_count", load_count, 0);
    $display("reload+fetch data=0x%04h busy=%0b", fetch_data, busy);
    wait_load("reload2_clear_cycles");
    send_word(16'h5555, 1'b1, 1'b1);
    chk("r1_load_count", load_count, 1);
    do_fetch("r1_addr1", 8'd1, 16'h0000);
    do_fetch("r1_addr0", 8'd0, 16'h5555);
    step();
    chk("hold_valid", fetch_valid, 0);
    chk("hold_data", fetch_data, 32'h5555);

    // Reset in the middle of a load
    reload = 1'b1;
    step();
    reload = 1'b0;
    wait_load("reload3_clear_cycles");
    send_word(16'hAAAA, 1'b0, 1'b0);
    send_word(16'hBBBB, 1'b0, 1'b0);
    chk("mid_load_count", load_count, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 1);
    chk("mid_rst_ld_ready", ld_ready, 0);
    chk("mid_rst_load_count", load_count, 0);
    wait_load("mid_rst_clear_cycles");
    for (int i = 0; i < 5; i++) send_word(16'h1000 + 16'(i), (i == 4), 1'b0);
    chk("new5_load_count", load_count, 5);
    for (int i = 0; i < 5; i++) do_fetch("new5", 8'(i), 16'h1000 + 16'(i));
    do_fetch("new5_addr5", 8'd5, 16'h0000);

    // Loader held valid in RUN has no effect
    ld_valid = 1'b1;
    ld_data  = 16'hDEAD;
    ld_last  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("run_ld_ready", ld_ready, 0);
    end
    ld_valid = 1'b0;
    chk("run_ld_load_count", load_count, 5);
    chk("run_ld_prog_ready", prog_ready, 1);
    do_fetch("run_ld_addr5", 8'd5, 16'h0000);
    do_fetch("run_ld_addr0", 8'd0, 16'h1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
